data_mem_responder: RTL



---
 rtl/data_mem_responder.sv | 89 ++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a programmable wait-state latency, a one-cycle
// Ready completion pulse and saturating read/write access counters.
//
// state | meaning
// IDLE  | waiting for MemRead/MemWrite; request is latched on acceptance
// WAIT  | counting down wait states; access happens on the edge where cnt == 0
// RESP  | Ready high for this one cycle, then back to IDLE
module data_mem_responder #(
    parameter int NBITS   = 8,
    parameter int NWORDS  = 2 ** (NBITS - 2),
    parameter int LATENCY = 2,
    parameter int CNTW    = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NBITS-3:0]   Address,
    input  logic [NBITS-1:0]   WriteData,
    input  logic               MemRead,
    input  logic               MemWrite,
    output logic [NBITS-1:0]   ReadData,
    output logic               Ready,
    output logic               Busy,
    output logic [CNTW-1:0]    ReadCount,
    output logic [CNTW-1:0]    WriteCount
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t           state, state_nxt;
    logic [3:0]       cnt;
    logic [NBITS-3:0] addr_q;
    logic [NBITS-1:0] wdata_q;
    logic             wr_q;
    logic [NBITS-1:0] mem [NWORDS];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (MemRead || MemWrite) state_nxt = WAIT;
            WAIT:    if (cnt == 4'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            ReadData   <= '0;
            Ready      <= 1'b0;
            Busy       <= 1'b0;
            ReadCount  <= '0;
            WriteCount <= '0;
            for (int i = 0; i < NWORDS; i++) mem[i] <= '0;
        end else begin
            state <= state_nxt;
            // Outputs registered from the next state so they line up with state
            Ready <= (state_nxt == RESP);
            Busy  <= (state_nxt != IDLE);
            case (state)
                IDLE: begin
                    if (MemRead || MemWrite) begin
                        addr_q  <= Address;
                        wdata_q <= WriteData;
                        wr_q    <= MemWrite;
                        cnt     <= 4'(LATENCY - 1);
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else if (wr_q) begin
                        mem[addr_q] <= wdata_q;
                        if (WriteCount != '1) WriteCount <= WriteCount + CNTW'(1);
                    end else begin
                        ReadData <= mem[addr_q];
                        if (ReadCount != '1) ReadCount <= ReadCount + CNTW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
